// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline control: RAW-hazard stall, decode-branch flush, memory freeze, HALT drain.
// Optional performance counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal issue; hazards, flushes and memory freezes apply
// DRAIN   | HALT issued; fetch/decode flushed until in-flight writers retire
// HALTED  | pipe drained; everything frozen until reset
module pipe_hazard_ctrl #(
    parameter int REG_W     = 3,
    parameter int HAZ_DEPTH = 3,
    parameter int WB_BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] dec_rs,
    input  logic             dec_rs_used,
    input  logic [REG_W-1:0] dec_rt,
    input  logic             dec_rt_used,
    input  logic             dec_wr_en,
    input  logic [REG_W-1:0] dec_wr_reg,
    input  logic             dec_halt,
    input  logic             br_taken,
    input  logic             mem_stall,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             de_en,
    output logic             de_bubble,
    output logic             em_en,
    output logic             mw_en,
    output logic             stall_haz,
    output logic             halted
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_haz_cnt,
    output logic [31:0]      perf_flush_cnt,
    output logic [31:0]      perf_mem_cnt
`endif
);

    // With write-through register file the writeback entry never blocks decode.
    localparam int HAZ_CMP = HAZ_DEPTH - WB_BYPASS;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                              state;
    state_t                              state_nxt;
    logic                                fd_valid;
    logic                                fd_valid_nxt;
    logic [HAZ_DEPTH-1:0]                sb_v;
    logic [HAZ_DEPTH-1:0][REG_W-1:0]     sb_reg;
    logic                                hit;
    logic                                frozen;
    logic                                halt_issue;
    logic                                sb_new_v;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < HAZ_CMP; i++) begin
            if (sb_v[i] && ((dec_rs_used && (dec_rs == sb_reg[i])) ||
                            (dec_rt_used && (dec_rt == sb_reg[i])))) begin
                hit = 1'b1;
            end
        end
        hit = hit & fd_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_en        = 1'b0;
        fd_en        = 1'b0;
        fd_flush     = 1'b0;
        de_en        = 1'b0;
        de_bubble    = 1'b0;
        em_en        = 1'b0;
        mw_en        = 1'b0;
        halted       = (state == ST_HALTED);
        stall_haz    = hit & ~mem_stall & (state == ST_RUN);
        frozen       = mem_stall | (state == ST_HALTED);
        halt_issue   = (state == ST_RUN) & fd_valid & dec_halt & ~stall_haz & ~mem_stall;
        fd_valid_nxt = fd_valid;

        if (state == ST_HALTED) begin
            // everything held
        end else if (mem_stall) begin
            // whole pipe frozen
        end else if (stall_haz) begin
            de_en     = 1'b1;
            de_bubble = 1'b1;
            em_en     = 1'b1;
            mw_en     = 1'b1;
        end else if (state == ST_DRAIN) begin
            fd_en     = 1'b1;
            fd_flush  = 1'b1;
            de_en     = 1'b1;
            de_bubble = 1'b1;
            em_en     = 1'b1;
            mw_en     = 1'b1;
        end else begin
            pc_en     = 1'b1;
            fd_en     = 1'b1;
            de_en     = 1'b1;
            em_en     = 1'b1;
            mw_en     = 1'b1;
            fd_flush  = fd_valid & br_taken;
            de_bubble = ~fd_valid;
        end

        sb_new_v = fd_valid & dec_wr_en & ~de_bubble;

        if (fd_en) begin
            fd_valid_nxt = ~fd_flush & (state == ST_RUN) & ~halt_issue;
        end

        case (state)
            ST_RUN:    if (halt_issue) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (~|sb_v && !mem_stall) state_nxt = ST_HALTED;
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fd_valid <= 1'b0;
            sb_v     <= '0;
            sb_reg   <= '0;
        end else begin
            fd_valid <= fd_valid_nxt;
            if (!frozen) begin
                for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
                    sb_v[i]   <= sb_v[i-1];
                    sb_reg[i] <= sb_reg[i-1];
                end
                sb_v[0]   <= sb_new_v;
                sb_reg[0] <= dec_wr_reg;
            end
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    // Saturating event counters; they stop once the pipe has halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_haz_cnt   <= '0;
            perf_flush_cnt <= '0;
            perf_mem_cnt   <= '0;
        end else if (state != ST_HALTED) begin
            if (stall_haz && (perf_haz_cnt != 32'hFFFF_FFFF)) begin
                perf_haz_cnt <= perf_haz_cnt + 32'd1;
            end
            if (fd_flush && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
            if (mem_stall && (perf_mem_cnt != 32'hFFFF_FFFF)) begin
                perf_mem_cnt <= perf_mem_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, corner-case sequences,
// and random stimulus against a queue-based reference model of the pipeline.
module tb_pipe_hazard_ctrl;

    localparam int REG_W     = 3;
    localparam int HAZ_DEPTH = 3;
    localparam int WB_BYPASS = 1;

    // {pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, mw_en, stall_haz, halted}
    localparam logic [8:0] O_RUN = 9'b110101100;
    localparam logic [8:0] O_BUB = 9'b110111100;
    localparam logic [8:0] O_STL = 9'b000111110;
    localparam logic [8:0] O_FLS = 9'b111101100;
    localparam logic [8:0] O_FRZ = 9'b000000000;
    localparam logic [8:0] O_DRN = 9'b011111100;
    localparam logic [8:0] O_HLT = 9'b000000001;

    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic             rsu;
        logic [REG_W-1:0] rt;
        logic             rtu;
        logic             we;
        logic [REG_W-1:0] wr;
        logic             h;
        logic             br;
        logic             ms;
        logic [8:0]       exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] dec_rs, dec_rt, dec_wr_reg;
    logic             dec_rs_used, dec_rt_used, dec_wr_en, dec_halt, br_taken, mem_stall;
    logic             pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, mw_en, stall_haz, halted;
    logic [8:0]       outs;

    int n_vec = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(.REG_W(REG_W), .HAZ_DEPTH(HAZ_DEPTH), .WB_BYPASS(WB_BYPASS)) dut (
        .clk(clk), .rst(rst),
        .dec_rs(dec_rs), .dec_rs_used(dec_rs_used),
        .dec_rt(dec_rt), .dec_rt_used(dec_rt_used),
        .dec_wr_en(dec_wr_en), .dec_wr_reg(dec_wr_reg),
        .dec_halt(dec_halt), .br_taken(br_taken), .mem_stall(mem_stall),
        .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush),
        .de_en(de_en), .de_bubble(de_bubble), .em_en(em_en), .mw_en(mw_en),
        .stall_haz(stall_haz), .halted(halted)
    );

    assign outs = {pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, mw_en, stall_haz, halted};

    always #5 clk = ~clk;

    // Reference model: in-flight writers as a queue of register numbers (-1 = no writer).
    int m_q[$];
    bit m_fdv;
    int m_mode;   // 0 running, 1 draining, 2 halted

    function automatic vec_t mk(input logic [REG_W-1:0] rs, input logic rsu,
                                input logic [REG_W-1:0] rt, input logic rtu,
                                input logic we, input logic [REG_W-1:0] wr,
                                input logic h, input logic br, input logic ms,
                                input logic [8:0] exp);
        vec_t v;
        v.rs = rs; v.rsu = rsu; v.rt = rt; v.rtu = rtu; v.we = we; v.wr = wr;
        v.h = h; v.br = br; v.ms = ms; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        dec_rs = v.rs; dec_rs_used = v.rsu; dec_rt = v.rt; dec_rt_used = v.rtu;
        dec_wr_en = v.we; dec_wr_reg = v.wr; dec_halt = v.h; br_taken = v.br; mem_stall = v.ms;
    endtask

    task automatic check(input string name, input logic [8:0] exp);
        n_vec++;
        if (outs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (pc fd flush de bub em mw stall halted)",
                     name, outs, exp);
        end
    endtask

    // Drive at posedge+1, compare at negedge, leave at the next posedge+1.
    task automatic apply(input vec_t v, input string name);
        drive(v);
        @(negedge clk);
        check(name, v.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUB));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic model_reset();
        m_q = {};
        repeat (HAZ_DEPTH) m_q.push_back(-1);
        m_fdv  = 1'b0;
        m_mode = 0;
    endtask

    task automatic model_cycle(input vec_t v, output logic [8:0] e);
        bit haz, stl, pc, fd, fl, de, bub, em, mw, hissue, empty;
        int newent;
        haz = 1'b0;
        for (int i = 0; i < HAZ_DEPTH - WB_BYPASS; i++) begin
            if (m_fdv && m_q[i] >= 0 &&
                ((v.rsu && int'(v.rs) == m_q[i]) || (v.rtu && int'(v.rt) == m_q[i])))
                haz = 1'b1;
        end
        stl = haz && !v.ms && m_mode == 0;
        pc = 0; fd = 0; fl = 0; de = 0; bub = 0; em = 0; mw = 0;
        if (m_mode == 2 || v.ms) begin
            pc = 0;
        end else if (stl) begin
            de = 1; bub = 1; em = 1; mw = 1;
        end else if (m_mode == 1) begin
            fd = 1; fl = 1; de = 1; bub = 1; em = 1; mw = 1;
        end else begin
            pc = 1; fd = 1; de = 1; em = 1; mw = 1;
            fl = m_fdv && v.br;
            bub = !m_fdv;
        end
        e = {pc, fd, fl, de, bub, em, mw, stl, m_mode == 2};
        hissue = m_mode == 0 && m_fdv && v.h && !stl && !v.ms;
        empty = 1'b1;
        foreach (m_q[i]) if (m_q[i] >= 0) empty = 1'b0;
        if (!(v.ms || m_mode == 2)) begin
            newent = (m_fdv && v.we && !bub) ? int'(v.wr) : -1;
            m_q.push_front(newent);
            void'(m_q.pop_back());
        end
        if (fd) m_fdv = !fl && m_mode == 0 && !hissue;
        if (hissue) m_mode = 1;
        else if (m_mode == 1 && empty && !v.ms) m_mode = 2;
    endtask

    vec_t tbl [12];

    initial begin
        vec_t       v;
        logic [8:0] e;
        int         hcnt;

        do_reset();
        check("reset_state", O_BUB);

        // independent instructions: only the first cycle after reset is a bubble
        for (int i = 0; i < 10; i++)
            apply(mk(5, 1, 6, 1, 1, 3'(i % 4), 0, 0, 0, (i == 0) ? O_BUB : O_RUN),
                  $sformatf("indep[%0d]", i));

        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUB);
        tbl[1]  = mk(1, 1, 0, 0, 1, 3, 0, 0, 0, O_RUN);
        tbl[2]  = mk(3, 1, 0, 0, 1, 4, 0, 0, 0, O_STL);
        tbl[3]  = mk(3, 1, 0, 0, 1, 4, 0, 0, 0, O_STL);
        tbl[4]  = mk(3, 1, 0, 0, 1, 4, 0, 0, 0, O_RUN);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_FLS);
        tbl[6]  = mk(4, 1, 0, 0, 1, 6, 0, 0, 0, O_BUB);
        tbl[7]  = mk(6, 1, 4, 1, 1, 2, 0, 0, 0, O_RUN);
        tbl[8]  = mk(0, 0, 2, 1, 0, 0, 0, 1, 0, O_STL);
        tbl[9]  = mk(0, 0, 2, 1, 0, 0, 0, 1, 0, O_STL);
        tbl[10] = mk(0, 0, 2, 1, 0, 0, 0, 1, 0, O_FLS);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUB);
        do_reset();
        for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

        // memory freeze in the middle of a hazard stall
        do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUB), "ms_idle");
        apply(mk(0, 0, 0, 0, 1, 3, 0, 0, 0, O_RUN), "ms_wr3");
        apply(mk(3, 1, 0, 0, 0, 0, 0, 0, 0, O_STL), "ms_stall1");
        for (int i = 0; i < 4; i++)
            apply(mk(3, 1, 0, 0, 0, 0, 0, 1, 1, O_FRZ), $sformatf("ms_frz[%0d]", i));
        apply(mk(3, 1, 0, 0, 0, 0, 0, 0, 0, O_STL), "ms_stall2");
        apply(mk(3, 1, 0, 0, 0, 0, 0, 0, 0, O_RUN), "ms_issue");

        // HALT with two writers in flight, drain, sticky halt; then reset mid-drain
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUB), "h_idle");
            apply(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, O_RUN), "h_wr1");
            apply(mk(0, 0, 0, 0, 1, 2, 0, 0, 0, O_RUN), "h_wr2");
            apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_RUN), "h_halt");
            apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRN), "h_drain1");
            if (pass == 0) begin
                apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRN), "h_drain2");
                apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRN), "h_drain3");
                apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_HLT), "h_halted");
                apply(mk(1, 1, 2, 1, 1, 1, 1, 1, 0, O_HLT), "h_sticky1");
                apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_HLT), "h_sticky2");
            end else begin
                #1 rst = 1'b1;
                #1 check("h_async_rst", O_BUB);
                @(posedge clk);
                #1 rst = 1'b0;
            end
        end

        // random traffic against the reference model
        do_reset();
        model_reset();
        hcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            if (m_mode == 2) hcnt++;
            if (hcnt >= 4) begin
                drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUB));
                #1 rst = 1'b1;
                #1 check("rnd_async_rst", O_BUB);
                @(posedge clk);
                #1 rst = 1'b0;
                model_reset();
                hcnt = 0;
            end
            v = mk(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 7) == 0),
                   1'($urandom_range(0, 7) == 0), O_FRZ);
            model_cycle(v, e);
            v.exp = e;
            apply(v, $sformatf("rnd[%0d]", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
